// File: rtl/udp_buf_pkg.sv
// Shared types for the UDP receive word buffer: byte/word widths, the stored
// FIFO entry layout and the byte-packer states.
package udp_buf_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;

  typedef struct packed {
    logic              last;
    logic [WORD_W-1:0] data;
  } buf_word_t;

  typedef enum logic {
    EMPTY_HALF,
    HAVE_HI
  } pack_state_e;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock show-ahead FIFO: the head entry is visible on rd_data whenever
// empty is low, and a pop presents the next entry on the following cycle.
module sync_fifo_fwft #(
  parameter  int DEPTH = 512,
  parameter  int W     = 17,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          wr_ok,
  output logic          rd_ok,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;

  assign full  = (level_q == FULL_LVL);
  assign empty = (level_q == '0);
  // A write at full is refused even when a pop frees a slot this same cycle.
  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;

  assign rd_data = mem[rd_ptr_q];
  assign level   = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({wr_ok, rd_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/udp_rx_word_buf.sv
// UDP RX byte stream to 16-bit word FIFO: packs byte pairs (first byte high),
// tracks dropped words with a sticky overflow flag and exports debug strobes.
module udp_rx_word_buf
  import udp_buf_pkg::*;
#(
  parameter  int DEPTH = 512,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic [AW:0]       level,
  output logic              overflow,
  input  logic              ovf_clr,
  output logic              dbg_wr,
  output logic              dbg_rd,
  output logic              dbg_full,
  output logic [WORD_W-1:0] dbg_data
);

  pack_state_e       state_q, state_d;
  logic [BYTE_W-1:0] hi_q, hi_d;
  logic              push_q, push_d;
  buf_word_t         push_word_q, push_word_d;
  logic              overflow_q, overflow_d;
  logic              dbg_wr_q, dbg_wr_d;
  logic              dbg_rd_q, dbg_rd_d;
  logic              dbg_full_q, dbg_full_d;
  logic [WORD_W-1:0] dbg_data_q, dbg_data_d;

  buf_word_t head;
  logic      fifo_full, fifo_empty, wr_ok, rd_ok;

  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    push_d      = 1'b0;
    push_word_d = push_word_q;
    if (in_valid) begin
      unique case (state_q)
        EMPTY_HALF: begin
          if (in_last) begin
            push_d      = 1'b1;
            push_word_d = '{last: 1'b1, data: {in_data, 8'h00}};
          end else begin
            hi_d    = in_data;
            state_d = HAVE_HI;
          end
        end
        HAVE_HI: begin
          push_d      = 1'b1;
          push_word_d = '{last: in_last, data: {hi_q, in_data}};
          state_d     = EMPTY_HALF;
        end
        default: state_d = EMPTY_HALF;
      endcase
    end
  end

  sync_fifo_fwft #(
    .DEPTH (DEPTH),
    .W     ($bits(buf_word_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push_q),
    .wr_data (push_word_q),
    .rd_en   (out_ready),
    .rd_data (head),
    .wr_ok   (wr_ok),
    .rd_ok   (rd_ok),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  always_comb begin
    overflow_d = overflow_q;
    if (ovf_clr)             overflow_d = 1'b0;
    if (push_q && fifo_full) overflow_d = 1'b1;
    dbg_wr_d   = wr_ok;
    dbg_rd_d   = rd_ok;
    dbg_full_d = fifo_full;
    dbg_data_d = wr_ok ? push_word_q.data : dbg_data_q;
  end

  // Storage is not reset, so gate the head with valid to keep outputs at 0.
  assign out_valid = ~fifo_empty;
  assign out_data  = out_valid ? head.data : '0;
  assign out_last  = out_valid & head.last;
  assign overflow  = overflow_q;
  assign dbg_wr    = dbg_wr_q;
  assign dbg_rd    = dbg_rd_q;
  assign dbg_full  = dbg_full_q;
  assign dbg_data  = dbg_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY_HALF;
      push_q     <= 1'b0;
      overflow_q <= 1'b0;
      dbg_wr_q   <= 1'b0;
      dbg_rd_q   <= 1'b0;
      dbg_full_q <= 1'b0;
      dbg_data_q <= '0;
    end else begin
      state_q    <= state_d;
      push_q     <= push_d;
      overflow_q <= overflow_d;
      dbg_wr_q   <= dbg_wr_d;
      dbg_rd_q   <= dbg_rd_d;
      dbg_full_q <= dbg_full_d;
      dbg_data_q <= dbg_data_d;
    end
  end

  always_ff @(posedge clk) begin
    hi_q        <= hi_d;
    push_word_q <= push_word_d;
  end

endmodule
